code_lock_core: RTL and testbench

Parametrised successor to the 6-bit two-button password lock. It is a single-clock FSM that conditions raw button levels, collects a binary code of length CODE_LEN, and compares it against a stored code. Wrong attempts trigger an exponential lockout, and idle entries time out. An optional run-time code-change path is included. The block sits between the board button synchronisers and the LED/status decode in the top-level chip interface.

---
 rtl/code_lock_pkg.sv | 39 +++
 rtl/code_lock_core_btn_edge.sv | 21 ++
 rtl/code_lock_core.sv | 222 ++++++++++++++++++++++
 tb/tb_code_lock_core.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/code_lock_pkg.sv
// Shared types and helpers for the code lock: FSM state encoding, button
// indices into the vectored edge detector, and the lockout-length function.
package code_lock_pkg;

  localparam int unsigned STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    S_IDLE    = 3'd0,
    S_ENTRY   = 3'd1,
    S_CHECK   = 3'd2,
    S_PASS    = 3'd3,
    S_FAIL    = 3'd4,
    S_LOCKOUT = 3'd5,
    S_PROGRAM = 3'd6
  } state_t;

  localparam int unsigned BTN_ENTER0  = 0;
  localparam int unsigned BTN_ENTER1  = 1;
  localparam int unsigned BTN_CONFIRM = 2;
  localparam int unsigned BTN_CLEAR   = 3;
  localparam int unsigned BTN_CHANGE  = 4;
  localparam int unsigned BTN_N       = 5;

  // Value presented on state_o for a given state.
  function automatic logic [STATE_W-1:0] state_code(input state_t s);
    return STATE_W'(s);
  endfunction

  // Lockout length: base doubled per consecutive failure beyond the first.
  function automatic int unsigned lock_len(input int unsigned base,
                                           input int unsigned shift_max,
                                           input logic [1:0]  fails);
    int unsigned sh;
    sh = (fails == 2'd0) ? 0 : 32'(fails) - 1;
    if (sh > shift_max) sh = shift_max;
    return base << sh;
  endfunction

endpackage

// File: rtl/code_lock_core_btn_edge.sv
// Vectored button register with rising-edge detect; one event per press,
// released only by a low sample in between.
module btn_edge #(
  parameter int unsigned N = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic [N-1:0] btn,
  output logic [N-1:0] rise_c
);

  logic [N-1:0] btn_q;

  always_ff @(posedge clock) begin
    if (reset) btn_q <= '0;
    else       btn_q <= btn;
  end

  assign rise_c = btn & ~btn_q;

endmodule

// File: rtl/code_lock_core.sv
// Binary-code lock FSM with exponential lockout and entry timeout.
// Define CODE_LOCK_PROGRAM_EN to enable the run-time code-change path.
module code_lock_core
  import code_lock_pkg::*;
#(
  parameter int unsigned         CODE_LEN       = 6,
  parameter logic [CODE_LEN-1:0] DEFAULT_CODE   = CODE_LEN'(6'b101101),
  parameter int unsigned         TIMEOUT        = 360,
  parameter int unsigned         PASS_HOLD      = 36,
  parameter int unsigned         FAIL_HOLD      = 36,
  parameter int unsigned         LOCK_BASE      = 90,
  parameter int unsigned         LOCK_SHIFT_MAX = 2
) (
  input  logic                                                clock,
  input  logic                                                reset,
  input  logic                                                enter0,
  input  logic                                                enter1,
  input  logic                                                confirm,
  input  logic                                                clear,
  input  logic                                                change_code,
  output logic                                                unlocked,
  output logic                                                fail,
  output logic                                                locked_out,
  output logic [2:0]                                          state_o,
  output logic [$clog2(CODE_LEN+2)-1:0]                       digits_entered,
  output logic [1:0]                                          fail_count,
  output logic [$clog2((LOCK_BASE<<LOCK_SHIFT_MAX)+1)-1:0]    lock_remaining
);

  localparam int unsigned CNT_W   = $clog2(CODE_LEN + 2);
  localparam int unsigned LR_W    = $clog2((LOCK_BASE << LOCK_SHIFT_MAX) + 1);
  localparam int unsigned TMR_MAX = (TIMEOUT > PASS_HOLD)
                                    ? ((TIMEOUT > FAIL_HOLD) ? TIMEOUT : FAIL_HOLD)
                                    : ((PASS_HOLD > FAIL_HOLD) ? PASS_HOLD : FAIL_HOLD);
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  logic [BTN_N-1:0]    btn;
  logic [BTN_N-1:0]    ev_c;
  logic                multi_c, clr_v, cfm_v, dig_v, dig_b, any_ev;

  state_t              state_q, state_d;
  logic [CODE_LEN-1:0] buf_q, buf_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TMR_W-1:0]    tmr_q, tmr_d;
  logic [1:0]          fc_q, fc_d;
  logic [LR_W-1:0]     lr_q, lr_d;
  logic [CODE_LEN-1:0] code_q;

  always_comb begin
    btn              = '0;
    btn[BTN_ENTER0]  = enter0;
    btn[BTN_ENTER1]  = enter1;
    btn[BTN_CONFIRM] = confirm;
    btn[BTN_CLEAR]   = clear;
    btn[BTN_CHANGE]  = change_code;
  end

  btn_edge #(.N(BTN_N)) u_btn_edge (
    .clock  (clock),
    .reset  (reset),
    .btn    (btn),
    .rise_c (ev_c)
  );

  // Clear beats everything; colliding digit/confirm events cancel each other.
  assign multi_c = (ev_c[BTN_ENTER0] & ev_c[BTN_ENTER1]) |
                   (ev_c[BTN_ENTER0] & ev_c[BTN_CONFIRM]) |
                   (ev_c[BTN_ENTER1] & ev_c[BTN_CONFIRM]);
  assign clr_v   = ev_c[BTN_CLEAR];
  assign cfm_v   = ev_c[BTN_CONFIRM] & ~multi_c & ~clr_v;
  assign dig_v   = (ev_c[BTN_ENTER0] | ev_c[BTN_ENTER1]) & ~multi_c & ~clr_v;
  assign dig_b   = ev_c[BTN_ENTER1];
  assign any_ev  = |ev_c;

`ifdef CODE_LOCK_PROGRAM_EN
  logic [CODE_LEN-1:0] code_d;
  logic                chg_v;
  assign chg_v = ev_c[BTN_CHANGE] & ~clr_v;

  always_ff @(posedge clock) begin
    if (reset) code_q <= DEFAULT_CODE;
    else       code_q <= code_d;
  end
`else
  assign code_q = DEFAULT_CODE;
`endif

  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    tmr_d   = tmr_q;
    fc_d    = fc_q;
    lr_d    = lr_q;
`ifdef CODE_LOCK_PROGRAM_EN
    code_d  = code_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (dig_v) begin
          buf_d   = CODE_LEN'(dig_b);
          cnt_d   = CNT_W'(1);
          tmr_d   = '0;
          state_d = S_ENTRY;
        end
      end

      S_ENTRY, S_PROGRAM: begin
        // Any button edge, honoured or not, restarts the idle timer.
        if (any_ev) begin
          tmr_d = '0;
        end else if (tmr_q == TMR_W'(TIMEOUT - 1)) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end

        if (clr_v) begin
          state_d = S_IDLE;
          buf_d   = '0;
          cnt_d   = '0;
        end else if (cfm_v) begin
          if (state_q == S_ENTRY) begin
            state_d = S_CHECK;
          end else begin
`ifdef CODE_LOCK_PROGRAM_EN
            if (cnt_q == CNT_W'(CODE_LEN)) code_d = buf_q;
`endif
            state_d = S_IDLE;
            buf_d   = '0;
            cnt_d   = '0;
          end
        end else if (dig_v) begin
          buf_d = (buf_q << 1) | CODE_LEN'(dig_b);
          if (cnt_q != CNT_W'(CODE_LEN + 1)) cnt_d = cnt_q + CNT_W'(1);
        end
      end

      S_CHECK: begin
        if ((cnt_q == CNT_W'(CODE_LEN)) && (buf_q == code_q)) begin
          fc_d    = 2'd0;
          state_d = S_PASS;
        end else begin
          if (fc_q != 2'd3) fc_d = fc_q + 2'd1;
          state_d = S_FAIL;
        end
        buf_d = '0;
        cnt_d = '0;
        tmr_d = '0;
      end

      S_PASS: begin
`ifdef CODE_LOCK_PROGRAM_EN
        if (chg_v) begin
          state_d = S_PROGRAM;
          tmr_d   = '0;
        end else
`endif
        if (tmr_q == TMR_W'(PASS_HOLD - 1)) begin
          state_d = S_IDLE;
          tmr_d   = '0;
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_FAIL: begin
        if (tmr_q == TMR_W'(FAIL_HOLD - 1)) begin
          state_d = S_LOCKOUT;
          tmr_d   = '0;
          lr_d    = LR_W'(lock_len(LOCK_BASE, LOCK_SHIFT_MAX, fc_q));
        end else begin
          tmr_d = tmr_q + TMR_W'(1);
        end
      end

      S_LOCKOUT: begin
        if (lr_q <= LR_W'(1)) begin
          lr_d    = '0;
          state_d = S_IDLE;
        end else begin
          lr_d = lr_q - LR_W'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q    <= S_IDLE;
      buf_q      <= '0;
      cnt_q      <= '0;
      tmr_q      <= '0;
      fc_q       <= '0;
      lr_q       <= '0;
      unlocked   <= 1'b0;
      fail       <= 1'b0;
      locked_out <= 1'b0;
    end else begin
      state_q    <= state_d;
      buf_q      <= buf_d;
      cnt_q      <= cnt_d;
      tmr_q      <= tmr_d;
      fc_q       <= fc_d;
      lr_q       <= lr_d;
      unlocked   <= (state_d == S_PASS);
      fail       <= (state_d == S_FAIL);
      locked_out <= (state_d == S_LOCKOUT);
    end
  end

  assign state_o        = state_code(state_q);
  assign digits_entered = cnt_q;
  assign fail_count     = fc_q;
  assign lock_remaining = lr_q;

endmodule

// File: tb/tb_code_lock_core.sv
// Directed bench for code_lock_core with default parameters; the code-change
// scenario follows CODE_LOCK_PROGRAM_EN.
module tb_code_lock_core;
  import code_lock_pkg::*;

  localparam int unsigned PASS_HOLD = 36;
  localparam int unsigned FAIL_HOLD = 36;

  logic       clock = 1'b0;
  logic       reset, enter0, enter1, confirm, clear, change_code;
  logic       unlocked, fail, locked_out;
  logic [2:0] state_o;
  logic [2:0] digits_entered;
  logic [1:0] fail_count;
  logic [8:0] lock_remaining;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  code_lock_core dut (
    .clock          (clock),
    .reset          (reset),
    .enter0         (enter0),
    .enter1         (enter1),
    .confirm        (confirm),
    .clear          (clear),
    .change_code    (change_code),
    .unlocked       (unlocked),
    .fail           (fail),
    .locked_out     (locked_out),
    .state_o        (state_o),
    .digits_entered (digits_entered),
    .fail_count     (fail_count),
    .lock_remaining (lock_remaining)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic set_btn(input int idx, input logic v);
    case (idx)
      BTN_ENTER0:  enter0      = v;
      BTN_ENTER1:  enter1      = v;
      BTN_CONFIRM: confirm     = v;
      BTN_CLEAR:   clear       = v;
      default:     change_code = v;
    endcase
  endtask

  task automatic press(input int idx);
    set_btn(idx, 1'b1);
    tick();
    set_btn(idx, 1'b0);
    tick();
  endtask

  task automatic enter_code(input logic [15:0] code, input int n);
    for (int i = n - 1; i >= 0; i--) press(code[i] ? BTN_ENTER1 : BTN_ENTER0);
  endtask

  // Enter a correct code and confirm; returns one edge into PASS.
  task automatic unlock(input logic [15:0] code, input int n);
    enter_code(code, n);
    check("unl_digits", digits_entered, n);
    confirm = 1'b1;
    tick();
    check("unl_check_state", state_o, S_CHECK);
    check("unl_check_unlocked", unlocked, 0);
    confirm = 1'b0;
    tick();
    check("unl_pass_state", state_o, S_PASS);
    check("unl_unlocked", unlocked, 1);
    check("unl_fail_count", fail_count, 0);
  endtask

  // Finish a PASS window of which 'used' cycles were already spent after entry.
  task automatic finish_pass(input int used);
    tick(PASS_HOLD - 1 - used);
    check("pass_last_cycle", unlocked, 1);
    tick();
    check("pass_over_unlocked", unlocked, 0);
    check("pass_over_state", state_o, S_IDLE);
  endtask

  // Wrong attempt followed by the full FAIL and LOCKOUT windows.
  task automatic fail_attempt(input logic [15:0] code, input int n,
                              input int exp_fc, input int exp_len);
    enter_code(code, n);
    check("bad_digits", digits_entered, (n > 7) ? 7 : n);
    confirm = 1'b1;
    tick();
    check("bad_check_state", state_o, S_CHECK);
    confirm = 1'b0;
    tick();
    check("bad_fail_state", state_o, S_FAIL);
    check("bad_fail_flag", fail, 1);
    check("bad_fail_count", fail_count, exp_fc);
    check("bad_digits_cleared", digits_entered, 0);
    tick(FAIL_HOLD - 1);
    check("bad_fail_last", fail, 1);
    tick();
    check("lock_state", state_o, S_LOCKOUT);
    check("lock_flag", locked_out, 1);
    check("lock_len", lock_remaining, exp_len);
    press(BTN_CLEAR);
    check("lock_clear_ignored", lock_remaining, exp_len - 2);
    tick(exp_len - 3);
    check("lock_last", lock_remaining, 1);
    check("lock_last_flag", locked_out, 1);
    tick();
    check("lock_over_state", state_o, S_IDLE);
    check("lock_over_flag", locked_out, 0);
    check("lock_over_rem", lock_remaining, 0);
  endtask

  initial begin
    reset = 1'b1;
    enter0 = 1'b0; enter1 = 1'b0; confirm = 1'b0; clear = 1'b0; change_code = 1'b0;
    tick(2);
    check("rst_state", state_o, S_IDLE);
    check("rst_unlocked", unlocked, 0);
    check("rst_fail", fail, 0);
    check("rst_locked", locked_out, 0);
    check("rst_digits", digits_entered, 0);
    check("rst_fail_count", fail_count, 0);
    check("rst_lock_rem", lock_remaining, 0);
    reset = 1'b0;
    tick();

    // Timeout: "10" then silence; leaves on the 360th quiet edge.
    set_btn(BTN_ENTER1, 1'b1);
    tick();
    check("to_first_digit_state", state_o, S_ENTRY);
    check("to_first_digit_cnt", digits_entered, 1);
    set_btn(BTN_ENTER1, 1'b0);
    tick();
    press(BTN_ENTER0);
    check("to_two_digits", digits_entered, 2);
    tick(358);
    check("to_quiet_359_state", state_o, S_ENTRY);
    tick();
    check("to_quiet_360_state", state_o, S_IDLE);
    check("to_digits", digits_entered, 0);
    check("to_fail_count", fail_count, 0);

    // Correct code.
    unlock(16'b101101, 6);
    finish_pass(0);

    // Lockout escalation, saturating at 360.
    fail_attempt(16'b111111, 6, 1, 90);
    fail_attempt(16'b111111, 6, 2, 180);
    fail_attempt(16'b111111, 6, 3, 360);
    fail_attempt(16'b111111, 6, 3, 360);

    // Clear then correct code.
    press(BTN_ENTER1);
    press(BTN_ENTER0);
    check("clr_two_digits", digits_entered, 2);
    press(BTN_CLEAR);
    check("clr_state", state_o, S_IDLE);
    check("clr_digits", digits_entered, 0);
    unlock(16'b101101, 6);
    finish_pass(0);

    // Overflow: 7 digits, and 8 digits whose low 6 bits match the code.
    fail_attempt(16'b1011011, 7, 1, 90);
    fail_attempt(16'b11101101, 8, 2, 180);

    // Simultaneous events.
    press(BTN_ENTER1);
    enter0 = 1'b1; enter1 = 1'b1;
    tick();
    check("sim_digits_unchanged", digits_entered, 1);
    enter0 = 1'b0; enter1 = 1'b0;
    tick();
    confirm = 1'b1; clear = 1'b1;
    tick();
    check("sim_clr_cfm_state", state_o, S_IDLE);
    check("sim_clr_cfm_digits", digits_entered, 0);
    confirm = 1'b0; clear = 1'b0;
    tick();

    // A held button produces a single event.
    enter0 = 1'b1;
    tick(3);
    check("hold_one_event", digits_entered, 1);
    enter0 = 1'b0;
    tick();
    press(BTN_CLEAR);

    // Button held through reset fires on the first cycle after reset.
    enter1 = 1'b1;
    reset = 1'b1;
    tick();
    check("hrst_state", state_o, S_IDLE);
    reset = 1'b0;
    tick();
    check("hrst_event_state", state_o, S_ENTRY);
    check("hrst_event_cnt", digits_entered, 1);
    enter1 = 1'b0;
    tick();
    press(BTN_CLEAR);

`ifdef CODE_LOCK_PROGRAM_EN
    unlock(16'b101101, 6);
    press(BTN_CHANGE);
    check("prog_state", state_o, S_PROGRAM);
    check("prog_unlocked", unlocked, 0);
    enter_code(16'b110100, 6);
    check("prog_digits", digits_entered, 6);
    confirm = 1'b1;
    tick();
    check("prog_done_state", state_o, S_IDLE);
    check("prog_done_digits", digits_entered, 0);
    confirm = 1'b0;
    tick();
    fail_attempt(16'b101101, 6, 1, 90);
    unlock(16'b110100, 6);
    finish_pass(0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    unlock(16'b101101, 6);
    finish_pass(0);
`else
    unlock(16'b101101, 6);
    press(BTN_CHANGE);
    check("chg_ignored_state", state_o, S_PASS);
    finish_pass(2);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
